// File: rtl/unpad_check.sv
// ============================================================================
// Module  : unpad_check
// Purpose : Reads back a padded 64-byte block, locates the 0x80 marker by
//           scanning backward, checks the zero fill and the trailing length
//           byte, and reports the recovered length with a status code.
// Config  : UNPAD_LEN_CHECK_EN - read and compare the trailing length byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unpad_check #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int BLOCK_SIZE = 64,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] memAddrLine,
    output logic                  memRdEn,
    input  logic [DATA_WIDTH-1:0] memDataLine,
    output logic [DATA_WIDTH-1:0] dataLen,
    output logic [1:0]            err,
    output logic                  valid,
    output logic                  finish
);

    localparam int OFFW = $clog2(BLOCK_SIZE);

    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef UNPAD_LEN_CHECK_EN
    localparam logic [2:0] S_LEN   = 3'd1;
`endif
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] E_OK        = 2'b00;
    localparam logic [1:0] E_BAD_PAD   = 2'b01;
    localparam logic [1:0] E_NO_MARKER = 2'b10;
`ifdef UNPAD_LEN_CHECK_EN
    localparam logic [1:0] E_LEN_MISM  = 2'b11;
    localparam logic [OFFW-1:0] C_LEN_OFF   = OFFW'(BLOCK_SIZE - 1);
    localparam logic [OFFW-1:0] C_FIRST_OFF = OFFW'(BLOCK_SIZE - 1);
`else
    localparam logic [OFFW-1:0] C_FIRST_OFF = OFFW'(BLOCK_SIZE - 2);
`endif
    localparam logic [DATA_WIDTH-1:0] C_MARK = DATA_WIDTH'(8'h80);

    logic [2:0]            state_q, state_d;
    logic [OFFW-1:0]       iss_q, iss_d;        // offset being issued this cycle
    logic                  iss_act_q, iss_act_d;
    logic                  rdv_q, rdv_d;        // a read was issued last cycle
    logic [OFFW-1:0]       rdoff_q, rdoff_d;    // offset of that read
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [1:0]            err_q, err_d;
`ifdef UNPAD_LEN_CHECK_EN
    logic [DATA_WIDTH-1:0] lenbyte_q, lenbyte_d;
`endif
    logic                  hit;

    always_comb begin
        state_d   = state_q;
        iss_d     = iss_q;
        iss_act_d = iss_act_q;
        rdv_d     = rdv_q;
        rdoff_d   = rdoff_q;
        len_d     = len_q;
        err_d     = err_q;
`ifdef UNPAD_LEN_CHECK_EN
        lenbyte_d = lenbyte_q;
`endif
        hit       = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdv_d     = 1'b0;
                iss_act_d = 1'b0;
                if (start) begin
                    len_d     = '0;
                    err_d     = E_OK;
                    iss_d     = C_FIRST_OFF;
                    iss_act_d = 1'b1;
`ifdef UNPAD_LEN_CHECK_EN
                    state_d   = S_LEN;
`else
                    state_d   = S_SCAN;
`endif
                end
            end
`ifdef UNPAD_LEN_CHECK_EN
            S_LEN: begin
                rdv_d   = 1'b1;
                rdoff_d = iss_q;
                iss_d   = iss_q - OFFW'(1);
                state_d = S_SCAN;
            end
`endif
            S_SCAN: begin
                // Issue the next lower offset while judging the byte returned
                // for the previous one.
                rdv_d   = iss_act_q;
                rdoff_d = iss_q;
                if (iss_act_q) begin
                    if (iss_q == '0) iss_act_d = 1'b0;
                    else             iss_d     = iss_q - OFFW'(1);
                end
                if (rdv_q) begin
`ifdef UNPAD_LEN_CHECK_EN
                    if (rdoff_q == C_LEN_OFF) lenbyte_d = memDataLine;
                    else
`endif
                    begin
                        if (memDataLine == '0) begin
                            if (rdoff_q == '0) begin
                                err_d = E_NO_MARKER;
                                len_d = '0;
                                hit   = 1'b1;
                            end
                        end else if (memDataLine == C_MARK) begin
                            len_d = DATA_WIDTH'(rdoff_q);
                            hit   = 1'b1;
                        end else begin
                            err_d = E_BAD_PAD;
                            len_d = DATA_WIDTH'(rdoff_q);
                            hit   = 1'b1;
                        end
                    end
                end
                if (hit) begin
                    iss_act_d = 1'b0;
                    rdv_d     = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef UNPAD_LEN_CHECK_EN
                if ((err_q == E_OK) && (lenbyte_q != DATA_WIDTH'(len_q << 3)))
                    err_d = E_LEN_MISM;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iss_q     <= '0;
            iss_act_q <= 1'b0;
            rdv_q     <= 1'b0;
            rdoff_q   <= '0;
            len_q     <= '0;
            err_q     <= E_OK;
`ifdef UNPAD_LEN_CHECK_EN
            lenbyte_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            iss_q     <= iss_d;
            iss_act_q <= iss_act_d;
            rdv_q     <= rdv_d;
            rdoff_q   <= rdoff_d;
            len_q     <= len_d;
            err_q     <= err_d;
`ifdef UNPAD_LEN_CHECK_EN
            lenbyte_q <= lenbyte_d;
`endif
        end
    end

`ifdef UNPAD_LEN_CHECK_EN
    assign memRdEn = ((state_q == S_LEN) || (state_q == S_SCAN)) && iss_act_q;
`else
    assign memRdEn = (state_q == S_SCAN) && iss_act_q;
`endif
    assign memAddrLine = memRdEn ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(iss_q)) : 'z;
    assign dataLen     = len_q;
    assign err         = err_q;
    assign finish      = (state_q == S_DONE);
    assign valid       = (state_q == S_DONE) && (err_q == E_OK);

endmodule

`default_nettype wire

// File: doc/unpad_check.md
# unpad_check

Reader-side counterpart of the block padder: after a 64-byte block has been padded in shared byte memory, this block reads it back over the same address/data bus and recovers the message length. It scans backward from the end of the block to find the 0x80 marker, checks the zero fill, and compares the trailing length byte. It then reports the length plus a pass/fail code to the controller before the block is released to the hash core.

## Interface
- DATA_WIDTH, 8, memory data width and width of the length outputs
- ADDR_WIDTH, 10, memory address width
- BLOCK_SIZE, 64, block size in bytes; last byte holds the length field
- BASE_ADDR, 0, address of block byte 0
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  level request; sampled only in IDLE
- memAddrLine  output  ADDR_WIDTH  read address; high-Z when memRdEn=0 (shared bus)
- memRdEn  output  1  read strobe, one read per cycle
- memDataLine  input  DATA_WIDTH  read data, valid the cycle after the address (registered memory)
- dataLen  output  DATA_WIDTH  recovered message length in bytes (offset of 0x80 marker)
- err  output  2  00 OK, 01 BAD_PAD, 10 NO_MARKER, 11 LEN_MISMATCH
- valid  output  1  finish && err==00
- finish  output  1  result available, held in DONE

## Operation
- States: IDLE, LEN, SCAN, CHECK, DONE.
- IDLE: memRdEn=0. start=1 → LEN.
- LEN: issue read of offset BLOCK_SIZE-1 → SCAN with next issue offset BLOCK_SIZE-2.
- SCAN: each cycle issue offset a-1 and sample the byte at offset a, pipelined. The first sample is the length byte, stored in lenByte.
  - byte==0 → continue; at a==0 → err=NO_MARKER → CHECK.
  - byte==8'h80 → dataLen=a → CHECK.
  - any other byte → err=BAD_PAD, dataLen=a → CHECK.
- Issuing stops after offset 0. The speculative read of a-1 issued in the detecting cycle is discarded.
- CHECK: if err==00 and lenByte != (dataLen<<3) truncated to DATA_WIDTH → err=LEN_MISMATCH. Go to DONE with finish=1.
- DONE: finish, dataLen and err are held. start=0 → IDLE; start must drop before a new run.
- The valid dataLen range is 0..BLOCK_SIZE-2. A block with the length byte only (no marker) reports NO_MARKER or BAD_PAD.
- start deasserted mid-run is ignored; the run completes.

## Timing
- Reset values: finish=0, valid=0, err=00, dataLen=0, memRdEn=0, memAddrLine=Z; state=IDLE.
- rst mid-run aborts on the next edge. memRdEn drops at that edge and no further reads are issued.
- Edge E0 samples start in IDLE. Offset 63 is issued in cycle E0–E1. Byte at offset a is sampled at edge E(65-a).
- Marker at L: finish high after E(66-L). Latency is 4 cycles for L=62 and 66 cycles for L=0. Errors follow the same formula using the detecting offset a; NO_MARKER finishes after E66.
- memAddrLine = BASE_ADDR + offset, ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH.
- Length compare uses modulo-2^DATA_WIDTH arithmetic. Example: L=55 → expected 440 mod 256 = 8'hB8.

## Configuration
- UNPAD_LEN_CHECK_EN defined: behaviour as above.
- UNPAD_LEN_CHECK_EN undefined:
  - LEN state removed; IDLE → SCAN issues offset BLOCK_SIZE-2 first.
  - Every latency is one cycle shorter.
  - Offset BLOCK_SIZE-1 is never read; err=11 is never produced.

## Test plan
- Padded block L=5 (bytes 0..4=8'hAA, 5=8'h80, 6..62=0, 63=8'h28), start → finish after E61, dataLen=5, err=00, valid=1.
- L=0 (0x80 at 0, zeros, 63=0) → finish after E66, dataLen=0, valid=1. Message bytes equal to 0x80 at offsets 0..3 with L=4 → dataLen=4.
- Block 10 message bytes with byte 40=8'h11 → err=BAD_PAD, dataLen=40, finish after E26. Block all zero → err=NO_MARKER after E66.
- L=55 with byte 63=8'h00 → err=LEN_MISMATCH. With byte 63=8'hB8 → valid=1. With macro undefined, byte 63=8'h00 → valid=1, latency 10 for L=55.
- rst at E20 of an L=0 run → next edge: memRdEn=0, finish=0, state IDLE. Then start → full run OK. Hold start high through DONE → no restart until start toggles low/high.
